// File: rtl/exception_ctrl_pkg.sv
// Shared exception/CP0 definitions for the MEM-stage exception controller.
// Holds one-hot command codes, flag bit positions, CP0 field positions, FSM states.
package exception_ctrl_pkg;

   localparam int EXC_TYPE_BUS = 9;
   typedef logic [EXC_TYPE_BUS-1:0] exc_type_t;

   localparam int FLG_ERET = 0;
   localparam int FLG_IF   = 1;
   localparam int FLG_RI   = 2;
   localparam int FLG_OV   = 3;
   localparam int FLG_BP   = 4;
   localparam int FLG_SYS  = 5;
   localparam int FLG_ADEL = 6;
   localparam int FLG_ADES = 7;

   localparam exc_type_t EXC_TYPE_NONE = 9'h000;
   localparam exc_type_t EXC_TYPE_ERET = 9'h001;
   localparam exc_type_t EXC_TYPE_IF   = 9'h002;
   localparam exc_type_t EXC_TYPE_RI   = 9'h004;
   localparam exc_type_t EXC_TYPE_OV   = 9'h008;
   localparam exc_type_t EXC_TYPE_BP   = 9'h010;
   localparam exc_type_t EXC_TYPE_SYS  = 9'h020;
   localparam exc_type_t EXC_TYPE_ADEL = 9'h040;
   localparam exc_type_t EXC_TYPE_ADES = 9'h080;
   localparam exc_type_t EXC_TYPE_INT  = 9'h100;

   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;
   localparam int ST_BEV = 22;
   localparam int IM_HI  = 15;
   localparam int IM_LO  = 8;

   typedef enum logic [1:0] {
      BV_NONE,
      BV_PC,
      BV_ADDR
   } bv_sel_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRAIN,
      S_COMMIT,
      S_HOLD
   } state_e;

endpackage

// File: rtl/exception_ctrl_if.sv
// MEM-stage / CP0 exception port bundle.
// master: exception controller side; slave: pipeline + CP0 side.
interface exception_ctrl_if;
   import exception_ctrl_pkg::*;

   logic        mem_valid;
   logic [7:0]  mem_exc_flags;
   logic [31:0] mem_pc;
   logic [31:0] mem_addr;
   logic        mem_delayslot;
   logic        bus_busy;
   logic [31:0] cp0_status;
   logic [31:0] cp0_cause;
   logic [31:0] cp0_epc;
   logic [31:0] cp0_ebase;

   logic        stall_req;
   logic        mem_kill;
   exc_type_t   exception_type;
   logic        delayslot_flag;
   logic [31:0] current_pc_addr;
   logic [31:0] cp0_badvaddr_write_data;
   logic        flush;
   logic [31:0] flush_pc;

   modport master (
      input  mem_valid, mem_exc_flags, mem_pc, mem_addr,
      input  mem_delayslot, bus_busy,
      input  cp0_status, cp0_cause, cp0_epc, cp0_ebase,
      output stall_req, mem_kill, exception_type,
      output delayslot_flag, current_pc_addr,
      output cp0_badvaddr_write_data, flush, flush_pc
   );

   modport slave (
      output mem_valid, mem_exc_flags, mem_pc, mem_addr,
      output mem_delayslot, bus_busy,
      output cp0_status, cp0_cause, cp0_epc, cp0_ebase,
      input  stall_req, mem_kill, exception_type,
      input  delayslot_flag, current_pc_addr,
      input  cp0_badvaddr_write_data, flush, flush_pc
   );

endinterface

// File: rtl/exc_prio_enc.sv
// Fixed-priority exception encoder: INT > IF > RI > OV > BP > SYS > ADEL > ADES > ERET.
// Ports: flags/int_pend in; one-hot exc_type and BadVAddr source select out.
module exc_prio_enc
   import exception_ctrl_pkg::*;
(
   input  logic [7:0] flags,
   input  logic       int_pend,
   output exc_type_t  exc_type,
   output bv_sel_e    bv_sel
);

   always_comb begin
      exc_type = EXC_TYPE_NONE;
      bv_sel   = BV_NONE;
      // first matching item wins, so item order is the priority order
      case (1'b1)
         int_pend:       exc_type = EXC_TYPE_INT;
         flags[FLG_IF]: begin
            exc_type = EXC_TYPE_IF;
            bv_sel   = BV_PC;
         end
         flags[FLG_RI]:  exc_type = EXC_TYPE_RI;
         flags[FLG_OV]:  exc_type = EXC_TYPE_OV;
         flags[FLG_BP]:  exc_type = EXC_TYPE_BP;
         flags[FLG_SYS]: exc_type = EXC_TYPE_SYS;
         flags[FLG_ADEL]: begin
            exc_type = EXC_TYPE_ADEL;
            bv_sel   = BV_ADDR;
         end
         flags[FLG_ADES]: begin
            exc_type = EXC_TYPE_ADES;
            bv_sel   = BV_ADDR;
         end
         flags[FLG_ERET]: exc_type = EXC_TYPE_ERET;
         default: ;
      endcase
   end

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception controller: detects, drains the data bus, issues one CP0 command.
// Ports: clk, rst (async, active-high), bus (exception_ctrl_if.master).
module exception_ctrl
   import exception_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR_EXC = 32'hBFC0_0380,
   parameter logic [31:0] EBASE_OFFSET     = 32'h0000_0180
) (
   input  logic              clk,
   input  logic              rst,
   exception_ctrl_if.master  bus
);

   state_e      state, state_nx;
   logic        int_pend, detect, cap_en;
   logic        stall, kill;
   exc_type_t   win_type;
   bv_sel_e     win_bv;
   logic [31:0] win_badv, win_tgt;

   exc_type_t   cap_type;
   logic [31:0] cap_pc, cap_badv, cap_tgt;
   logic        cap_ds;

   exc_type_t   sel_type;
   logic [31:0] sel_pc, sel_badv, sel_tgt;
   logic        sel_ds;

   exc_type_t   out_type;
   logic [31:0] out_pc, out_badv, out_tgt;
   logic        out_ds, out_flush;

   logic        unused_bits;
   assign unused_bits = ^{bus.cp0_cause[31:16], bus.cp0_cause[7:0],
                          bus.cp0_status[31:23], bus.cp0_status[21:16],
                          bus.cp0_status[7:2], bus.cp0_ebase[11:0]};

   assign int_pend = bus.cp0_status[ST_IE] & ~bus.cp0_status[ST_EXL] &
                     (|(bus.cp0_cause[IM_HI:IM_LO] &
                        bus.cp0_status[IM_HI:IM_LO]));
   assign detect = bus.mem_valid & (int_pend | (|bus.mem_exc_flags));

   exc_prio_enc u_enc (
      .flags    (bus.mem_exc_flags),
      .int_pend (int_pend),
      .exc_type (win_type),
      .bv_sel   (win_bv)
   );

   always_comb begin
      win_badv = 32'h0;
      case (win_bv)
         BV_PC:   win_badv = bus.mem_pc;
         BV_ADDR: win_badv = bus.mem_addr;
         default: win_badv = 32'h0;
      endcase
   end

   always_comb begin
      if (win_type == EXC_TYPE_ERET)
         win_tgt = bus.cp0_epc;
      else if (bus.cp0_status[ST_BEV])
         win_tgt = RESET_VECTOR_EXC;
      else
         win_tgt = {bus.cp0_ebase[31:12], 12'h0} + EBASE_OFFSET;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      kill     = 1'b0;
      cap_en   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (detect) begin
               stall    = 1'b1;
               kill     = 1'b1;
               cap_en   = 1'b1;
               state_nx = bus.bus_busy ? S_DRAIN : S_COMMIT;
            end
         end
         S_DRAIN: begin
            stall = 1'b1;
            if (!bus.bus_busy) state_nx = S_COMMIT;
         end
         S_COMMIT: state_nx = S_HOLD;
         S_HOLD:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_type <= EXC_TYPE_NONE;
         cap_pc   <= 32'h0;
         cap_badv <= 32'h0;
         cap_tgt  <= 32'h0;
         cap_ds   <= 1'b0;
      end else if (cap_en) begin
         cap_type <= win_type;
         cap_pc   <= bus.mem_pc;
         cap_badv <= win_badv;
         cap_tgt  <= win_tgt;
         cap_ds   <= bus.mem_delayslot;
      end
   end

   // IDLE->COMMIT skips the capture register, so bypass it here
   assign sel_type = cap_en ? win_type          : cap_type;
   assign sel_pc   = cap_en ? bus.mem_pc        : cap_pc;
   assign sel_badv = cap_en ? win_badv          : cap_badv;
   assign sel_tgt  = cap_en ? win_tgt           : cap_tgt;
   assign sel_ds   = cap_en ? bus.mem_delayslot : cap_ds;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_type  <= EXC_TYPE_NONE;
         out_pc    <= 32'h0;
         out_badv  <= 32'h0;
         out_tgt   <= 32'h0;
         out_ds    <= 1'b0;
         out_flush <= 1'b0;
      end else if (state_nx == S_COMMIT) begin
         out_type  <= sel_type;
         out_pc    <= sel_pc;
         out_badv  <= sel_badv;
         out_tgt   <= sel_tgt;
         out_ds    <= sel_ds;
         out_flush <= 1'b1;
      end else begin
         out_type  <= EXC_TYPE_NONE;
         out_pc    <= 32'h0;
         out_badv  <= 32'h0;
         out_tgt   <= 32'h0;
         out_ds    <= 1'b0;
         out_flush <= 1'b0;
      end
   end

   assign bus.stall_req               = stall;
   assign bus.mem_kill                = kill;
   assign bus.exception_type          = out_type;
   assign bus.delayslot_flag          = out_ds;
   assign bus.current_pc_addr         = out_pc;
   assign bus.cp0_badvaddr_write_data = out_badv;
   assign bus.flush                   = out_flush;
   assign bus.flush_pc                = out_tgt;

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed scenarios plus random traffic.
// Reference model works from event timestamps and a priority list.
module tb_exception_ctrl;
   import exception_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   exception_ctrl_if bif ();

   exception_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // reference model state: timestamps rather than states
   longint cyc;
   longint free_at;
   longint commit_at;
   bit     waiting;
   logic [31:0] e_type, e_pc, e_badv, e_tgt;
   logic        e_ds;

   function automatic int winner(input logic intp, input logic [7:0] f);
      int order [9] = '{8, 1, 2, 3, 4, 5, 6, 7, 0};
      logic [8:0] v;
      v = {intp, f};
      for (int i = 0; i < 9; i++)
         if (v[order[i]]) return order[i];
      return -1;
   endfunction

   task automatic model_reset();
      free_at   = cyc;
      commit_at = -1;
      waiting   = 0;
   endtask

   task automatic eval();
      logic intp, det, fr, c;
      logic [31:0] st;
      int w;
      #1;
      st   = bif.cp0_status;
      intp = st[0] && !st[1] &&
             ((bif.cp0_cause[15:8] & st[15:8]) != 8'h0);
      det  = bif.mem_valid && (intp || bif.mem_exc_flags != 8'h0);
      fr   = (cyc >= free_at) && !waiting;
      c    = (cyc == commit_at);
      chk("stall", 32'(bif.stall_req), 32'((fr && det) || waiting));
      chk("kill", 32'(bif.mem_kill), 32'(fr && det));
      chk("type", 32'(bif.exception_type), c ? e_type : 32'h0);
      chk("flush", 32'(bif.flush), 32'(c));
      chk("flush_pc", bif.flush_pc, c ? e_tgt : 32'h0);
      chk("cur_pc", bif.current_pc_addr, c ? e_pc : 32'h0);
      chk("ds", 32'(bif.delayslot_flag), 32'(c && e_ds));
      chk("badv", bif.cp0_badvaddr_write_data, c ? e_badv : 32'h0);
      if (fr && det) begin
         w      = winner(intp, bif.mem_exc_flags);
         e_type = 32'h1 << w;
         e_pc   = bif.mem_pc;
         e_ds   = bif.mem_delayslot;
         if (w == 1) e_badv = bif.mem_pc;
         else if (w == 6 || w == 7) e_badv = bif.mem_addr;
         else e_badv = 32'h0;
         if (w == 0) e_tgt = bif.cp0_epc;
         else if (st[22]) e_tgt = 32'hBFC0_0380;
         else e_tgt = {bif.cp0_ebase[31:12], 12'h0} + 32'h180;
         waiting = 1;
      end
      if (waiting && !bif.bus_busy) begin
         commit_at = cyc + 1;
         free_at   = cyc + 3;
         waiting   = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic idle_in();
      bif.mem_valid     = 1'b0;
      bif.mem_exc_flags = 8'h0;
      bif.mem_pc        = 32'h0;
      bif.mem_addr      = 32'h0;
      bif.mem_delayslot = 1'b0;
      bif.bus_busy      = 1'b0;
      bif.cp0_status    = 32'h0040_0000;
      bif.cp0_cause     = 32'h0;
      bif.cp0_epc       = 32'h0;
      bif.cp0_ebase     = 32'h8000_0000;
   endtask

   task automatic run_idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         idle_in();
         eval();
      end
   endtask

   task automatic exc_in(input logic [7:0] f, input logic [31:0] pc,
                         input logic [31:0] addr, input logic busy);
      idle_in();
      bif.mem_valid     = 1'b1;
      bif.mem_exc_flags = f;
      bif.mem_pc        = pc;
      bif.mem_addr      = addr;
      bif.bus_busy      = busy;
   endtask

   initial begin
      cyc = 0;
      rst = 1'b1;
      idle_in();
      model_reset();
      #2;
      chk("rst_type", 32'(bif.exception_type), 32'h0);
      chk("rst_flush", 32'(bif.flush), 32'h0);
      chk("rst_pc", bif.flush_pc, 32'h0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      model_reset();
      run_idle(2);

      // RI, BEV=1, bus idle
      tick();
      exc_in(8'h04, 32'hBFC0_0100, 32'h0, 1'b0);
      eval();
      chk("ri_stall", 32'(bif.stall_req), 32'h1);
      tick();
      idle_in();
      eval();
      chk("ri_type", 32'(bif.exception_type), 32'(EXC_TYPE_RI));
      chk("ri_fpc", bif.flush_pc, 32'hBFC0_0380);
      chk("ri_cpc", bif.current_pc_addr, 32'hBFC0_0100);
      run_idle(3);

      // ADES with bus busy for three cycles
      tick();
      exc_in(8'h80, 32'h8000_0040, 32'h8000_0003, 1'b1);
      eval();
      chk("ades_kill", 32'(bif.mem_kill), 32'h1);
      for (int i = 0; i < 2; i++) begin
         tick();
         idle_in();
         bif.bus_busy = 1'b1;
         eval();
         chk("ades_drain", 32'(bif.stall_req), 32'h1);
      end
      tick();
      idle_in();
      eval();
      chk("ades_nocommit", 32'(bif.flush), 32'h0);
      tick();
      idle_in();
      eval();
      chk("ades_type", 32'(bif.exception_type), 32'(EXC_TYPE_ADES));
      chk("ades_badv", bif.cp0_badvaddr_write_data, 32'h8000_0003);
      run_idle(3);

      // INT beats OV; HOLD keeps it from being retaken
      tick();
      exc_in(8'h08, 32'h8000_0100, 32'h0, 1'b0);
      bif.cp0_status = 32'h0000_0401;
      bif.cp0_cause  = 32'h0000_0400;
      eval();
      tick();
      exc_in(8'h00, 32'h8000_0104, 32'h0, 1'b0);
      bif.cp0_status = 32'h0000_0401;
      bif.cp0_cause  = 32'h0000_0400;
      eval();
      chk("int_type", 32'(bif.exception_type), 32'(EXC_TYPE_INT));
      chk("int_fpc", bif.flush_pc, 32'h8000_0180);
      tick();
      exc_in(8'h00, 32'h8000_0108, 32'h0, 1'b0);
      bif.cp0_status = 32'h0000_0403;
      bif.cp0_cause  = 32'h0000_0400;
      eval();
      chk("int_hold_stall", 32'(bif.stall_req), 32'h0);
      tick();
      exc_in(8'h00, 32'h8000_010C, 32'h0, 1'b0);
      bif.cp0_status = 32'h0000_0403;
      bif.cp0_cause  = 32'h0000_0400;
      eval();
      run_idle(2);

      // ERET, BEV=0
      tick();
      exc_in(8'h01, 32'h8000_0200, 32'h1234_5678, 1'b0);
      bif.cp0_status = 32'h0;
      bif.cp0_epc    = 32'h8000_1234;
      eval();
      tick();
      idle_in();
      eval();
      chk("eret_type", 32'(bif.exception_type), 32'(EXC_TYPE_ERET));
      chk("eret_fpc", bif.flush_pc, 32'h8000_1234);
      chk("eret_badv", bif.cp0_badvaddr_write_data, 32'h0);
      run_idle(3);

      // SYS in delay slot, BEV=0, EBase
      tick();
      exc_in(8'h20, 32'h8000_0300, 32'h0, 1'b0);
      bif.cp0_status    = 32'h0;
      bif.cp0_ebase     = 32'h8000_2000;
      bif.mem_delayslot = 1'b1;
      eval();
      tick();
      idle_in();
      eval();
      chk("sys_fpc", bif.flush_pc, 32'h8000_2180);
      chk("sys_ds", 32'(bif.delayslot_flag), 32'h1);
      run_idle(3);

      // reset in DRAIN
      tick();
      exc_in(8'h40, 32'h8000_0400, 32'h8000_0011, 1'b1);
      eval();
      tick();
      idle_in();
      bif.bus_busy = 1'b1;
      eval();
      rst = 1'b1;
      #1;
      chk("rstd_stall", 32'(bif.stall_req), 32'h0);
      chk("rstd_type", 32'(bif.exception_type), 32'h0);
      chk("rstd_flush", 32'(bif.flush), 32'h0);
      idle_in();
      tick();
      rst = 1'b0;
      model_reset();
      idle_in();
      eval();
      for (int i = 0; i < 4; i++) begin
         tick();
         idle_in();
         eval();
         chk("rstd_nopulse", 32'(bif.exception_type), 32'h0);
      end

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         tick();
         bif.mem_valid     = ($urandom % 4) != 0;
         bif.mem_exc_flags = 8'h0;
         if (($urandom % 3) == 0)
            bif.mem_exc_flags = 8'(1 << ($urandom % 8));
         if (($urandom % 8) == 0)
            bif.mem_exc_flags = bif.mem_exc_flags | 8'(1 << ($urandom % 8));
         bif.mem_pc        = $urandom;
         bif.mem_addr      = $urandom;
         bif.mem_delayslot = 1'($urandom);
         bif.bus_busy      = ($urandom % 3) == 0;
         bif.cp0_status    = {9'h0, 1'($urandom), 6'h0,
                              8'($urandom), 6'h0,
                              (($urandom % 4) == 0), (($urandom % 4) != 0)};
         bif.cp0_cause     = (($urandom % 4) == 0) ?
                             {16'h0, 8'($urandom), 8'h0} : 32'h0;
         bif.cp0_epc       = $urandom;
         bif.cp0_ebase     = $urandom;
         eval();
      end
      run_idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
